// File: rtl/msdf_otf_converter.sv
// Converts a most-significant-digit-first radix-2 redundant digit stream to a
// two's-complement fraction using on-the-fly Q/QM conversion.
module msdf_otf_converter #(
  parameter int unsigned RADIX_MODE     = 8'd1,
  parameter string       ENCODING_MODE  = "signed-digit",
  parameter int unsigned ACCURATE_MAX   = 8'd8,
  parameter int unsigned DATA_LEN_WIDTH = 8'd5,
  parameter int unsigned DATA_WIDTH     = 8'd2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_LEN_WIDTH-1:0] i_cfg_len,
  output logic                      o_mbus_rrq,
  output logic [DATA_LEN_WIDTH-1:0] o_mbus_rlen,
  input  logic                      i_mbus_rready,
  input  logic [DATA_WIDTH-1:0]     i_mbus_rdata,
  input  logic                      i_mbus_rvalid,
  input  logic                      i_mbus_rlast,
  output logic [ACCURATE_MAX:0]     o_res_data,
  output logic [DATA_LEN_WIDTH-1:0] o_res_len,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic                      o_res_err,
  output logic                      o_busy
);

  localparam int unsigned               RW          = ACCURATE_MAX + 1;
  localparam logic [DATA_LEN_WIDTH-1:0] MAX_LEN     = DATA_LEN_WIDTH'(ACCURATE_MAX);
  localparam bit                        BORROW_SAVE = (ENCODING_MODE == "borrow-save");
  // Only radix-2 digits are understood; any other radix never consumes digits.
  localparam bit                        RADIX_OK    = (RADIX_MODE == 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_OUT} state_t;

  state_t                    state_q;
  logic [RW-1:0]             q_q, qm_q;
  logic [DATA_LEN_WIDTH-1:0] cnt_q;
  logic                      err_q;
  logic [DATA_LEN_WIDTH-1:0] rlen_q;
  logic [RW-1:0]             res_data_q;
  logic [DATA_LEN_WIDTH-1:0] res_len_q;
  logic                      res_err_q;
  logic                      res_valid_q;

  logic                      dig_pos, dig_neg, dig_bad;
  logic [RW-1:0]             q_d, qm_d;
  logic [DATA_LEN_WIDTH-1:0] cnt_d;
  logic                      err_d;
  logic [RW-1:0]             res_shifted;

  always_comb begin
    dig_pos = 1'b0;
    dig_neg = 1'b0;
    dig_bad = 1'b0;
    if (BORROW_SAVE) begin
      case (i_mbus_rdata[1:0])
        2'b01:   dig_pos = 1'b1;
        2'b11:   dig_neg = 1'b1;
        2'b10:   dig_bad = 1'b1;
        default: ;
      endcase
    end else begin
      case (i_mbus_rdata[1:0])
        2'b10:   dig_pos = 1'b1;
        2'b01:   dig_neg = 1'b1;
        default: ;
      endcase
    end
  end

  // Next Q/QM/count for the current digit; digits past the fraction width only flag err.
  always_comb begin
    q_d   = q_q;
    qm_d  = qm_q;
    cnt_d = cnt_q;
    err_d = err_q | dig_bad;
    if (cnt_q < MAX_LEN) begin
      cnt_d = cnt_q + DATA_LEN_WIDTH'(1);
      if (dig_pos) begin
        q_d  = {q_q[RW-2:0], 1'b1};
        qm_d = {q_q[RW-2:0], 1'b0};
      end else if (dig_neg) begin
        q_d  = {qm_q[RW-2:0], 1'b1};
        qm_d = {qm_q[RW-2:0], 1'b0};
      end else begin
        q_d  = {q_q[RW-2:0], 1'b0};
        qm_d = {qm_q[RW-2:0], 1'b1};
      end
    end else begin
      err_d = 1'b1;
    end
    res_shifted = q_d << (MAX_LEN - cnt_d);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      qm_q        <= '1;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rlen_q      <= '0;
      res_data_q  <= '0;
      res_len_q   <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_mbus_rready) begin
            state_q <= S_REQ;
            rlen_q  <= i_cfg_len;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        S_REQ: state_q <= S_RECV;
        S_RECV: begin
          if (i_mbus_rvalid && RADIX_OK) begin
            q_q   <= q_d;
            qm_q  <= qm_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (i_mbus_rlast) begin
              state_q     <= S_OUT;
              res_data_q  <= res_shifted;
              res_len_q   <= cnt_d;
              res_err_q   <= err_d;
              res_valid_q <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (i_res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mbus_rrq  = (state_q == S_REQ);
  assign o_mbus_rlen = rlen_q;
  assign o_res_data  = res_data_q;
  assign o_res_len   = res_len_q;
  assign o_res_err   = res_err_q;
  assign o_res_valid = res_valid_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
